// File: rtl/can_tx_scheduler_pkg.sv
// Shared types and constants for the CAN TX mailbox scheduler: FSM states,
// core register map, DLCF status bits, completion codes and the arbitration key.
package can_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WR_ID,
    ST_WR_D0,
    ST_WR_D1,
    ST_WR_GO,
    ST_POLL,
    ST_EVAL
  } state_e;

  typedef enum logic [1:0] {
    STS_OK        = 2'b00,
    STS_ABORTED   = 2'b01,
    STS_RETRY_EXH = 2'b10,
    STS_BIT_ERR   = 2'b11
  } status_e;

  // Core register offsets; the host field selects use the same numbering.
  localparam logic [1:0] REG_ID   = 2'd0;
  localparam logic [1:0] REG_DLCF = 2'd1;
  localparam logic [1:0] REG_D0   = 2'd2;
  localparam logic [1:0] REG_D1   = 2'd3;

  localparam int unsigned DLCF_RTS   = 8;
  localparam int unsigned DLCF_LOSTF = 9;
  localparam int unsigned DLCF_BITF  = 10;
  localparam int unsigned DLCF_ACKF  = 11;

  localparam int unsigned KEY_W = 30;

  // Bus-arbitration order key: a standard frame beats an extended one with the
  // same 11-bit base ID because its SRR/IDE position carries a 0.
  function automatic logic [KEY_W-1:0] can_key(input logic [31:0] id_word);
    if (id_word[31]) return {id_word[28:18], 1'b1, id_word[17:0]};
    else             return {id_word[10:0], 1'b0, 18'h0};
  endfunction

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Register-bus bundle between the scheduler (master) and the CAN core (slave).
interface can_tx_scheduler_if;
  logic        cs;
  logic [1:0]  rs;
  logic [3:0]  bytesel;
  logic [31:0] d;
  logic [31:0] q;

  modport master (output cs, output rs, output bytesel, output d, input q);
  modport slave  (input cs, input rs, input bytesel, input d, output q);
endinterface

// File: rtl/can_mb_select.sv
// Combinational minimum finder: lowest key among pending mailboxes, ties going
// to the lowest index.
module can_mb_select
  import can_sched_pkg::*;
#(
  parameter int unsigned NMB = 4
) (
  input  logic [NMB-1:0]            pend,
  input  logic [NMB-1:0][KEY_W-1:0] keys,
  output logic                      found,
  output logic [$clog2(NMB)-1:0]    idx
);

  localparam int unsigned MBW = $clog2(NMB);

  logic [KEY_W-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '1;
    // Strict less-than keeps the earlier (lower) index on equal keys.
    for (int unsigned i = 0; i < NMB; i++) begin
      if (pend[i] && (!found || keys[i] < best)) begin
        found = 1'b1;
        idx   = MBW'(i);
        best  = keys[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN TX scheduler: arbitrates pending mailboxes by ID key, loads the winner
// into the CAN core, polls for completion and handles retry/abort.
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int unsigned NMB       = 4,
  parameter int unsigned MAX_RETRY = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   host_wr,
  input  logic [$clog2(NMB)-1:0] host_mb,
  input  logic [1:0]             host_sel,
  input  logic [31:0]            host_d,
  input  logic [NMB-1:0]         host_send,
  input  logic [NMB-1:0]         host_abort,
  output logic                   can_cs,
  output logic [1:0]             can_rs,
  output logic [3:0]             can_bytesel,
  output logic [31:0]            can_d,
  input  logic [31:0]            can_q,
  output logic [NMB-1:0]         pending,
  output logic                   active,
  output logic [$clog2(NMB)-1:0] active_mb,
  output logic                   done,
  output logic [$clog2(NMB)-1:0] done_mb,
  output logic [1:0]             done_status
);

  localparam int unsigned MBW = $clog2(NMB);
  localparam int unsigned RW  = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  logic [31:0] mb_id_q  [NMB];
  logic [3:0]  mb_dlc_q [NMB];
  logic [31:0] mb_d0_q  [NMB];
  logic [31:0] mb_d1_q  [NMB];

  state_e           state_q, state_d;
  logic [NMB-1:0]   pending_q, pending_d;
  logic             active_q, active_d;
  logic [MBW-1:0]   active_mb_q, active_mb_d;
  logic             abort_req_q, abort_req_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             lost_q, lost_d;
  logic             bit_q, bit_d;
  logic             ack_q, ack_d;

  logic                      wr_ok;
  logic [NMB-1:0][KEY_W-1:0] keys;
  logic                      sel_found;
  logic [MBW-1:0]            sel_idx;
  logic                      abort_active;
  logic                      eval_clear;
  logic [RW-1:0]             retry_inc;
  logic                      unused_can_q;

  assign unused_can_q = ^{can_q[31:12], can_q[7:0]};

  // Mailbox contents are plain storage with no reset.
  assign wr_ok = host_wr && !(active_q && host_mb == active_mb_q);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      case (host_sel)
        REG_ID:   mb_id_q[host_mb]  <= host_d;
        REG_DLCF: mb_dlc_q[host_mb] <= host_d[3:0];
        REG_D0:   mb_d0_q[host_mb]  <= host_d;
        default:  mb_d1_q[host_mb]  <= host_d;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NMB; i++) keys[i] = can_key(mb_id_q[i]);
  end

  can_mb_select #(.NMB(NMB)) u_sel (
    .pend  (pending_q),
    .keys  (keys),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign abort_active = active_q && host_abort[active_mb_q];

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    active_d    = active_q;
    active_mb_d = active_mb_q;
    abort_req_d = abort_req_q | abort_active;
    retry_d     = retry_q;
    lost_d      = lost_q;
    bit_d       = bit_q;
    ack_d       = ack_q;
    retry_inc   = retry_q + 1'b1;
    eval_clear  = 1'b0;
    can_cs      = 1'b0;
    can_rs      = REG_ID;
    can_bytesel = 4'b0000;
    can_d       = '0;
    done        = 1'b0;
    done_mb     = active_mb_q;
    done_status = STS_OK;

    case (state_q)
      ST_IDLE: if (|pending_q) state_d = ST_SELECT;
      ST_SELECT: begin
        if (sel_found) begin
          active_d    = 1'b1;
          active_mb_d = sel_idx;
          if (sel_idx != active_mb_q) retry_d = '0;
          state_d     = ST_WR_ID;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ID: begin
        can_cs      = 1'b1;
        can_rs      = REG_ID;
        can_bytesel = 4'b1111;
        can_d       = {mb_id_q[active_mb_q][31:30], 1'b0, mb_id_q[active_mb_q][28:0]};
        state_d     = ST_WR_D0;
      end
      ST_WR_D0: begin
        can_cs      = 1'b1;
        can_rs      = REG_D0;
        can_bytesel = 4'b1111;
        can_d       = mb_d0_q[active_mb_q];
        state_d     = ST_WR_D1;
      end
      ST_WR_D1: begin
        can_cs      = 1'b1;
        can_rs      = REG_D1;
        can_bytesel = 4'b1111;
        can_d       = mb_d1_q[active_mb_q];
        state_d     = ST_WR_GO;
      end
      ST_WR_GO: begin
        // Low two bytes only: sets rts and DLC, leaves divisor/IRQ enables alone.
        can_cs      = 1'b1;
        can_rs      = REG_DLCF;
        can_bytesel = 4'b0011;
        can_d       = {23'h0, 1'b1, 4'h0, mb_dlc_q[active_mb_q]};
        state_d     = ST_POLL;
      end
      ST_POLL: begin
        can_cs      = 1'b1;
        can_rs      = REG_DLCF;
        can_bytesel = 4'b0000;
        lost_d      = can_q[DLCF_LOSTF];
        bit_d       = can_q[DLCF_BITF];
        ack_d       = can_q[DLCF_ACKF];
        if (!can_q[DLCF_RTS]) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        eval_clear = 1'b1;
        if (abort_req_q || abort_active) done_status = STS_ABORTED;
        else if (bit_q)                  done_status = STS_BIT_ERR;
        else if (ack_q && !lost_q)       done_status = STS_OK;
        else if (retry_inc >= MAX_R)     done_status = STS_RETRY_EXH;
        else begin
          // Retry: drop ownership so SELECT re-arbitrates against newer frames.
          eval_clear  = 1'b0;
          retry_d     = retry_inc;
          active_d    = 1'b0;
          abort_req_d = 1'b0;
          state_d     = ST_SELECT;
        end
        if (eval_clear) begin
          done        = 1'b1;
          retry_d     = '0;
          active_d    = 1'b0;
          abort_req_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eval_clear) pending_d[active_mb_q] = 1'b0;
    pending_d = pending_d | host_send;
    for (int unsigned i = 0; i < NMB; i++) begin
      if (host_abort[i] && !(active_q && MBW'(i) == active_mb_q)) pending_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      active_q    <= 1'b0;
      active_mb_q <= '0;
      abort_req_q <= 1'b0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      bit_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_q    <= active_d;
      active_mb_q <= active_mb_d;
      abort_req_q <= abort_req_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      bit_q       <= bit_d;
      ack_q       <= ack_d;
    end
  end

  assign pending   = pending_q;
  assign active    = active_q;
  assign active_mb = active_mb_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler with a small behavioural CAN core model
// answering DLCF polls after a programmable busy time.
module tb_can_tx_scheduler;
  import can_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_wr;
  logic [1:0]  host_mb;
  logic [1:0]  host_sel;
  logic [31:0] host_d;
  logic [3:0]  host_send;
  logic [3:0]  host_abort;
  logic [3:0]  pending;
  logic        active;
  logic [1:0]  active_mb;
  logic        done;
  logic [1:0]  done_mb;
  logic [1:0]  done_status;

  always #5 clk = ~clk;

  can_tx_scheduler_if bus ();

  can_tx_scheduler #(.NMB(4), .MAX_RETRY(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_wr     (host_wr),
    .host_mb     (host_mb),
    .host_sel    (host_sel),
    .host_d      (host_d),
    .host_send   (host_send),
    .host_abort  (host_abort),
    .can_cs      (bus.cs),
    .can_rs      (bus.rs),
    .can_bytesel (bus.bytesel),
    .can_d       (bus.d),
    .can_q       (bus.q),
    .pending     (pending),
    .active      (active),
    .active_mb   (active_mb),
    .done        (done),
    .done_mb     (done_mb),
    .done_status (done_status)
  );

  // Core model: busy (rts=1) for poll_len cycles after each GO write.
  int   poll_len = 20;
  logic ack_m = 1'b1, lost_m = 1'b0, bit_m = 1'b0;
  int   cnt = 0, go_cnt = 0, done_cnt = 0, viol = 0;
  logic go_seen;

  assign go_seen = bus.cs && bus.rs == 2'd1 && bus.bytesel == 4'b0011;
  assign bus.q = {20'h0, ack_m && cnt == 0, bit_m && cnt == 0, lost_m && cnt == 0,
                  cnt != 0, 8'h0};

  always @(posedge clk) begin
    if (go_seen) begin
      cnt    <= poll_len;
      go_cnt <= go_cnt + 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (bus.cs && ((bus.rs == 2'd0 && bus.bytesel == 4'b0000) ||
                   (bus.rs == 2'd1 && bus.bytesel[3:2] != 2'b00)))
      viol <= viol + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mb_write(input logic [1:0] mb, input logic [31:0] id, input logic [3:0] dlc,
                          input logic [31:0] d0, input logic [31:0] d1);
    for (int s = 0; s < 4; s++) begin
      host_wr  = 1'b1;
      host_mb  = mb;
      host_sel = 2'(s);
      host_d   = (s == 0) ? id : (s == 1) ? {28'h0, dlc} : (s == 2) ? d0 : d1;
      tick();
    end
    host_wr = 1'b0;
  endtask

  task automatic send(input logic [3:0] m);
    host_send = m;
    tick();
    host_send = '0;
  endtask

  task automatic abort(input logic [3:0] m);
    host_abort = m;
    tick();
    host_abort = '0;
  endtask

  task automatic wait_cs(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.cs) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_poll(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.cs && bus.rs == 2'd1 && bus.bytesel == 4'b0000) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int limit, output int cycles);
    bit ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (done) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, gb, dc;
    reset = 1'b1; host_wr = 1'b0; host_mb = '0; host_sel = '0; host_d = '0;
    host_send = '0; host_abort = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_cs", 32'(bus.cs), 32'h0);
    check("rst_rs", 32'(bus.rs), 32'h0);
    check("rst_bytesel", 32'(bus.bytesel), 32'h0);
    check("rst_d", bus.d, 32'h0);
    check("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    tick();

    // Arbitration and load sequence: 0x0F0 beats 0x123.
    mb_write(2'd0, 32'h0000_0123, 4'd4, 32'h1111_1111, 32'h2222_2222);
    mb_write(2'd1, 32'h0000_00F0, 4'd8, 32'hDEAD_BEEF, 32'h0123_4567);
    send(4'b0011);
    wait_cs("t1_wait_id");
    check("t1_id_rs", 32'(bus.rs), 32'd0);
    check("t1_id_bytesel", 32'(bus.bytesel), 32'hF);
    check("t1_id_d", bus.d, 32'h0000_00F0);
    check("t1_active", 32'(active), 32'd1);
    check("t1_active_mb", 32'(active_mb), 32'd1);
    @(negedge clk);
    check("t1_d0_rs", 32'(bus.rs), 32'd2);
    check("t1_d0_d", bus.d, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_d1_rs", 32'(bus.rs), 32'd3);
    check("t1_d1_d", bus.d, 32'h0123_4567);
    @(negedge clk);
    check("t1_go_rs", 32'(bus.rs), 32'd1);
    check("t1_go_bytesel", 32'(bus.bytesel), 32'h3);
    check("t1_go_d", bus.d, 32'h0000_0108);
    // 21 POLL cycles (20 busy + 1 idle sample) then EVAL.
    wait_done("t1_done1", 100, cyc);
    check("t1_poll_len", 32'(cyc), 32'd22);
    check("t1_done_mb", 32'(done_mb), 32'd1);
    check("t1_done_sts", 32'(done_status), 32'(STS_OK));
    @(negedge clk);
    check("t1_pend_after", 32'(pending), 32'h1);
    check("t1_active_after", 32'(active), 32'd0);
    wait_cs("t1_wait_mb0");
    check("t1_mb0_sel", 32'(active_mb), 32'd0);
    check("t1_mb0_id", bus.d, 32'h0000_0123);
    wait_done("t1_done0", 100, cyc);
    check("t1_done0_mb", 32'(done_mb), 32'd0);
    check("t1_done0_sts", 32'(done_status), 32'(STS_OK));
    check("t1_bus_rules", 32'(viol), 32'd0);

    // Lost arbitration every attempt: 7 attempts then retries exhausted.
    tick();
    lost_m = 1'b1; ack_m = 1'b0; poll_len = 3;
    mb_write(2'd2, 32'h0000_0050, 4'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    gb = go_cnt;
    send(4'b0100);
    wait_done("t2_done", 500, cyc);
    check("t2_done_mb", 32'(done_mb), 32'd2);
    check("t2_done_sts", 32'(done_status), 32'(STS_RETRY_EXH));
    check("t2_attempts", 32'(go_cnt - gb), 32'd7);
    @(negedge clk);
    check("t2_pending", 32'(pending), 32'h0);
    check("t2_active", 32'(active), 32'd0);
    check("t2_bus_rules", 32'(viol), 32'd0);
    lost_m = 1'b0; ack_m = 1'b1;

    // Abort of the in-flight frame is deferred to completion.
    poll_len = 10;
    gb = go_cnt;
    send(4'b0100);
    wait_poll("t3_wait_poll");
    abort(4'b0100);
    @(negedge clk);
    check("t3_still_pending", 32'(pending[2]), 32'd1);
    check("t3_still_polling", 32'(bus.cs), 32'd1);
    wait_done("t3_done", 100, cyc);
    check("t3_done_mb", 32'(done_mb), 32'd2);
    check("t3_done_sts", 32'(done_status), 32'(STS_ABORTED));
    check("t3_frame_complete", 32'(cnt), 32'd0);
    check("t3_one_attempt", 32'(go_cnt - gb), 32'd1);
    @(negedge clk);
    check("t3_pending", 32'(pending), 32'h0);

    // Abort of a waiting mailbox clears it silently.
    mb_write(2'd1, 32'h0000_0010, 4'd2, 32'h0, 32'h0);
    mb_write(2'd3, 32'h0000_0700, 4'd2, 32'h0, 32'h0);
    send(4'b1010);
    wait_cs("t4_wait_cs");
    check("t4_active_mb", 32'(active_mb), 32'd1);
    dc = done_cnt;
    abort(4'b1000);
    @(negedge clk);
    check("t4_pending", 32'(pending), 32'b0010);
    check("t4_no_done", 32'(done_cnt - dc), 32'd0);
    wait_done("t4_done", 100, cyc);
    check("t4_done_mb", 32'(done_mb), 32'd1);
    repeat (6) @(negedge clk);
    check("t4_idle_pending", 32'(pending), 32'h0);
    check("t4_done_count", 32'(done_cnt - dc), 32'd1);
    check("t4_bus_rules", 32'(viol), 32'd0);

    // Equal keys: lowest index wins.
    tick();
    mb_write(2'd1, 32'h0000_0200, 4'd3, 32'h0, 32'h0);
    mb_write(2'd2, 32'h0000_0200, 4'd3, 32'h0, 32'h0);
    send(4'b0110);
    wait_cs("t5_wait_cs1");
    check("t5_first_mb", 32'(active_mb), 32'd1);
    wait_done("t5_done1", 100, cyc);
    check("t5_done1_mb", 32'(done_mb), 32'd1);
    wait_cs("t5_wait_cs2");
    check("t5_second_mb", 32'(active_mb), 32'd2);
    wait_done("t5_done2", 100, cyc);
    check("t5_done2_mb", 32'(done_mb), 32'd2);

    // Reset in POLL abandons the frame without a done pulse.
    tick();
    poll_len = 30;
    send(4'b0010);
    wait_poll("t6_wait_poll");
    dc = done_cnt;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t6_pending", 32'(pending), 32'h0);
    check("t6_cs", 32'(bus.cs), 32'd0);
    check("t6_active", 32'(active), 32'd0);
    reset = 1'b0;
    repeat (40) tick();
    check("t6_no_done", 32'(done_cnt - dc), 32'd0);
    check("t6_bus_rules", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 SHALL have parameter NMB, default 4, meaning number of TX mailboxes (power of two, 2..8).
REQ-002 SHALL have parameter MAX_RETRY, default 7, meaning the number of attempts after which a frame is dropped.
REQ-003 SHALL have port clk, input, 1 bit: single clock.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port host_wr, input, 1 bit: mailbox field write strobe.
REQ-006 SHALL have port host_mb, input, log2(NMB) bits: mailbox index for the write.
REQ-007 SHALL have port host_sel, input, 2 bits: field select; 0=ID word (bit31 EXT, bit30 RTR, 28:0 ID), 1=DLC (3:0), 2=DATA0, 3=DATA1.
REQ-008 SHALL have port host_d, input, 32 bits: write data.
REQ-009 SHALL have port host_send, input, NMB bits: per-mailbox pulse that sets pending.
REQ-010 SHALL have port host_abort, input, NMB bits: per-mailbox pulse that cancels a frame.
REQ-011 SHALL have ports can_cs (output, 1), can_rs (output, 2), can_bytesel (output, 4) and can_d (output, 32): master port to the CAN core register bus.
REQ-012 SHALL have port can_q, input, 32 bits: combinational read data from the core.
REQ-013 SHALL have port pending, output, NMB bits: per-mailbox queued flag.
REQ-014 SHALL have ports active (output, 1) and active_mb (output, log2(NMB)): the mailbox currently owning the core.
REQ-015 SHALL have ports done (output, 1, one-cycle pulse), done_mb (output, log2(NMB)) and done_status (output, 2): 00 ok, 01 aborted, 10 retries exhausted, 11 bit error.

Function
REQ-016 SHALL be sequenced by states IDLE, SELECT, WR_ID, WR_D0, WR_D1, WR_GO, POLL, EVAL.
REQ-017 IDLE SHALL go to SELECT when pending is nonzero.
REQ-018 SELECT SHALL take one cycle and pick the pending mailbox with the lowest 30-bit key, where EXT=1 gives {ID[28:18],1,ID[17:0]} and EXT=0 gives {ID[10:0],0,18'h0}.
REQ-019 On equal keys, SELECT SHALL pick the lowest mailbox index.
REQ-020 SELECT SHALL latch active_mb and assert active.
REQ-021 WR_ID, WR_D0 and WR_D1 SHALL each take one cycle with can_cs=1, can_bytesel=4'b1111 and can_rs=0, 2 and 3 respectively.
REQ-022 WR_ID SHALL drive can_d={EXT,RTR,1'b0,ID}.
REQ-023 WR_D0 and WR_D1 SHALL drive DATA0 and DATA1 unmodified.
REQ-024 WR_GO SHALL take one cycle with can_cs=1, can_rs=1, can_bytesel=4'b0011 and can_d={23'h0,1'b1,4'h0,DLC}.
REQ-025 The scheduler SHALL never assert can_bytesel[3:2] on can_rs=1, so the baud divisor and IRQ enables are untouched.
REQ-026 The scheduler SHALL never access can_rs=0 with can_bytesel=0000, because that read clears the RX flags.
REQ-027 POLL SHALL drive can_cs=1, can_rs=1 and can_bytesel=0000 every cycle and sample can_q the same cycle.
REQ-028 POLL SHALL stay while can_q[8] (rts)=1 and go to EVAL when it is 0.
REQ-029 POLL SHALL capture lostf=can_q[9], bitf=can_q[10] and ackf=can_q[11].
REQ-030 The first POLL cycle SHALL immediately follow WR_GO.
REQ-031 EVAL SHALL resolve in this order: abort_req gives status 01.
REQ-032 Else, bitf SHALL give status 11.
REQ-033 Else, ackf=1 with lostf=0 SHALL give status 00.
REQ-034 Else (lost or no ACK), the retry count SHALL increment; if it reaches MAX_RETRY the status SHALL be 10, otherwise the mailbox stays pending and the next state is SELECT.
REQ-035 On each final status, EVAL SHALL pulse done for 1 cycle, clear pending[active_mb] and the retry count, deassert active, and go to IDLE.
REQ-036 On a retry, SELECT SHALL re-arbitrate, so a lower-key mailbox queued meanwhile preempts the retried one.
REQ-037 The retry count SHALL belong to the active frame and reset whenever a different mailbox is selected.
REQ-038 host_abort on a non-active mailbox SHALL clear pending next cycle, with no done pulse.
REQ-039 host_abort on the active mailbox SHALL set abort_req.
REQ-040 abort_req SHALL be honoured only in EVAL; the in-flight frame is not cut.
REQ-041 host_send on an already pending mailbox SHALL have no effect.
REQ-042 When host_send and host_abort hit the same mailbox in the same cycle, abort SHALL win.
REQ-043 A host_send and an EVAL clear of the same mailbox in the same cycle SHALL leave it pending.
REQ-044 host_wr to the active mailbox SHALL be ignored.
REQ-045 host_wr to any other mailbox, pending or not, SHALL be accepted.
REQ-046 can_cs SHALL be 0 in IDLE, SELECT and EVAL.

Reset
REQ-047 Reset SHALL clear pending, active, done, abort_req, the retry count and can_cs, and put the FSM in IDLE.
REQ-048 Reset SHALL set can_rs=0, can_bytesel=0 and can_d=0.
REQ-049 Mailbox contents SHALL be left unreset.
REQ-050 A reset during POLL SHALL abandon the frame with no done pulse; the core finishes on its own.

Structure
REQ-051 Package can_sched_pkg SHALL hold the state enum, core register offsets (ID=0, DLCF=1, D0=2, D1=3), DLCF bit positions (rts=8, lostf=9, bitf=10, ackf=11) and the status codes.
REQ-052 Mailbox key compare and selection SHALL be one sub-module, can_mb_select (combinational, NMB-wide minimum finder).

Verification
REQ-053 The bench SHALL load mb0 with ID 0x123 std and mb1 with 0x0F0 std, pulse host_send=0011, and require WR_ID first for mb1, d=0x000000F0 (EXT=0, RTR=0, ID 0x0F0).
REQ-054 The bench SHALL check WR_GO for mb1 with DLC=8, requiring can_d=0x00000108 and bytesel=0011.
REQ-055 The bench SHALL model rts=1 for 20 cycles, then ackf=1, and require done with status 00 for mb1, then mb0 selected.
REQ-056 The bench SHALL model lostf=1 on every attempt and require 7 attempts, then done with status 10 and pending cleared.
REQ-057 The bench SHALL abort mb2 while it is active in POLL and require the frame to complete, then done with status 01.
REQ-058 The bench SHALL abort a non-active pending mb3 and require pending[3]=0 next cycle with no done pulse.
REQ-059 The bench SHALL give equal keys to mb1 and mb2 and require mb1 to be selected.
REQ-060 The bench SHALL assert reset during POLL and require IDLE, pending=0 and can_cs=0 next cycle.
REQ-061 The bench SHALL assert in every test that no bus cycle uses rs=0 with bytesel=0000 and none uses rs=1 with bytesel[3:2] set.
